// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide adder that walks one 4-bit nibble per clock through a
// single rcadder4_bhv, holding the inter-nibble carry in a flop.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   begin an addition (accepted only in idle or done)
//   a, b   in   4*WORDS-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while nibble additions are in progress
//   done   out  one-cycle pulse after s/cout have been updated
//   s      out  registered 4*WORDS-bit sum
//   cout   out  registered carry-out of the top nibble
//
// rcadder4_bhv: 4-bit ripple-carry adder, {cout, s} = a + b + cin.

module nibble_serial_adder #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*WORDS-1:0]   a,
  input  logic [4*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*WORDS-1:0]   s,
  output logic                 cout
);

  localparam int unsigned W    = 4 * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      ra_q, ra_d;
  logic [W-1:0]      rb_q, rb_d;
  logic              c_q, c_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      s_q, s_d;
  logic              cout_q, cout_d;

  logic [3:0]        nib_a, nib_b, add_s;
  logic              add_cout;
  logic              accept;
  logic              last;

  // Operands are only taken when no addition is in flight.
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign last   = (idx_q == IdxW'(WORDS - 1));

  // Select the current nibble of each operand.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib_a = ra_q[4*i +: 4];
        nib_b = rb_q[4*i +: 4];
      end
    end
  end

  rcadder4_bhv u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (c_q),
    .s    (add_s),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAdd;
      StAdd:   if (last) state_d = StDone;
      StDone:  state_d = start ? StAdd : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy = (state_q == StAdd);
    done = (state_q == StDone);
  end

  assign s    = s_q;
  assign cout = cout_q;

  // Datapath next-state.
  always_comb begin
    ra_d   = ra_q;
    rb_d   = rb_q;
    c_d    = c_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    s_d    = s_q;
    cout_d = cout_q;
    if (accept) begin
      ra_d  = a;
      rb_d  = b;
      c_d   = cin;
      idx_d = '0;
    end else if (state_q == StAdd) begin
      c_d = add_cout;
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (idx_q == IdxW'(i)) begin
          acc_d[4*i +: 4] = add_s;
        end
      end
      if (last) begin
        // Publish the full sum including the nibble produced this cycle.
        s_d    = acc_d;
        cout_d = add_cout;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q   <= '0;
      rb_q   <= '0;
      c_q    <= 1'b0;
      idx_q  <= '0;
      acc_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      c_q    <= c_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

endmodule

module rcadder4_bhv (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0, cin};

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4, cin4, busy4, done4, cout4;
  logic [15:0] a4, b4, s4;
  logic        start1, cin1, busy1, done1, cout1;
  logic [3:0]  a1, b1, s1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [16:0] q4[$];
  logic [4:0]  q1[$];
  int          done_cyc4[$];
  int          done_cnt4 = 0;
  int          busy_cnt4 = 0;
  logic [16:0] exp4;
  logic [4:0]  exp1;

  nibble_serial_adder #(.WORDS(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .s     (s4),
    .cout  (cout4)
  );

  nibble_serial_adder #(.WORDS(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .s     (s1),
    .cout  (cout1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: pop the oldest expected result whenever a DUT reports done.
  always @(negedge clk) begin
    if (busy4) busy_cnt4++;
    if (done4) begin
      done_cnt4++;
      done_cyc4.push_back(cyc);
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL w4_unexpected_done got %h expected no result", {cout4, s4});
      end else begin
        exp4 = q4.pop_front();
        if ({cout4, s4} !== exp4) begin
          errors++;
          $display("FAIL w4_result got %h expected %h", {cout4, s4}, exp4);
        end
      end
    end
    if (done1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL w1_unexpected_done got %h expected no result", {cout1, s1});
      end else begin
        exp1 = q1.pop_front();
        if ({cout1, s1} !== exp1) begin
          errors++;
          $display("FAIL w1_result got %h expected %h", {cout1, s1}, exp1);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue4(input logic [15:0] x, input logic [15:0] y, input logic ci);
    int n = 0;
    while (busy4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("w4_accept_timeout", {31'b0, busy4}, 32'd0);
    a4 = x; b4 = y; cin4 = ci; start4 = 1'b1;
    q4.push_back({1'b0, x} + {1'b0, y} + {16'b0, ci});
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
  endtask

  task automatic issue1(input logic [3:0] x, input logic [3:0] y, input logic ci);
    int n = 0;
    while (busy1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("w1_accept_timeout", {31'b0, busy1}, 32'd0);
    a1 = x; b1 = y; cin1 = ci; start1 = 1'b1;
    q1.push_back({1'b0, x} + {1'b0, y} + {4'b0, ci});
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
  endtask

  task automatic drain4();
    for (int i = 0; i < 40 && q4.size() != 0; i++) @(negedge clk);
    check("w4_drain_timeout", q4.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain1();
    for (int i = 0; i < 40 && q1.size() != 0; i++) @(negedge clk);
    check("w1_drain_timeout", q1.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, n0, dc;
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #12;
    check("rst_busy4", {31'b0, busy4}, 32'd0);
    check("rst_done4", {31'b0, done4}, 32'd0);
    check("rst_s4",    {16'b0, s4},    32'd0);
    check("rst_cout4", {31'b0, cout4}, 32'd0);
    check("rst_s1",    {28'b0, s1},    32'd0);
    check("rst_busy1", {31'b0, busy1}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Full carry ripple: latency and busy length.
    busy_cnt4 = 0;
    n0 = done_cyc4.size();
    issue4(16'hFFFF, 16'hFFFF, 1'b0);
    c0 = cyc;
    drain4();
    check("lat_done_count", done_cyc4.size(), n0 + 1);
    if (done_cyc4.size() == n0 + 1) check("lat_done_cycle", done_cyc4[n0] - c0, 32'd4);
    check("lat_busy_cycles", busy_cnt4, 32'd4);
    check("ffff_s",    {16'b0, s4},    32'h0000FFFE);
    check("ffff_cout", {31'b0, cout4}, 32'd1);

    issue4(16'h000F, 16'h0001, 1'b0);
    drain4();
    issue4(16'h1234, 16'h4321, 1'b1);
    drain4();
    check("cin_s", {16'b0, s4}, 32'h00005556);

    // start during ADD must be dropped.
    dc = done_cnt4;
    issue4(16'h8000, 16'h8000, 1'b0);
    a4 = 16'h0001; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    drain4();
    repeat (8) @(posedge clk);
    #1;
    check("ignored_start_dones", done_cnt4 - dc, 32'd1);
    check("ignored_s",    {16'b0, s4},    32'h0);
    check("ignored_cout", {31'b0, cout4}, 32'd1);

    // Reset during the second ADD cycle aborts the operation.
    issue4(16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_s",    {16'b0, s4},    32'd0);
    check("abort_cout", {31'b0, cout4}, 32'd0);
    check("abort_busy", {31'b0, busy4}, 32'd0);
    void'(q4.pop_back());
    dc = done_cnt4;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt4, dc);
    issue4(16'h0002, 16'h0003, 1'b0);
    drain4();
    check("after_abort_s", {16'b0, s4}, 32'h5);

    // Back-to-back with start held high.
    n0 = done_cyc4.size();
    a4 = 16'h00FF; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
    q4.push_back(17'h00100);
    @(posedge clk); #1;
    a4 = 16'h7FFF; b4 = 16'h0001;
    q4.push_back(17'h08000);
    repeat (5) @(posedge clk);
    #1;
    start4 = 1'b0;
    drain4();
    check("b2b_done_count", done_cyc4.size(), n0 + 2);
    if (done_cyc4.size() == n0 + 2)
      check("b2b_spacing", done_cyc4[n0+1] - done_cyc4[n0], 32'd5);

    // Random sweep on both widths in parallel.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          issue4(16'($urandom), 16'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        drain4();
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          issue1(4'($urandom), 4'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        drain1();
      end
    join

    repeat (10) @(posedge clk);
    #1;
    check("w4_queue_empty", q4.size(), 32'd0);
    check("w1_queue_empty", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
